// File: rtl/spi_axi4_burst_bridge_if.sv
// AXI4 manager-side bus bundle used by spi_axi4_burst_bridge.
// The master modport is the bridge and the slave modport is the peripheral.
interface spi_axi4_burst_bridge_if #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int LEN_WIDTH     = 5
);
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic [LEN_WIDTH-1:0]     awlen;
  logic [2:0]               awburst;
  logic                     awvalid;
  logic                     awready;
  logic [DATA_WIDTH-1:0]    wdata;
  logic                     wlast;
  logic                     wvalid;
  logic                     wready;
  logic                     bvalid;
  logic                     bresp;
  logic                     bready;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [LEN_WIDTH-1:0]     arlen;
  logic [2:0]               arburst;
  logic                     arvalid;
  logic                     arready;
  logic [DATA_WIDTH-1:0]    rdata;
  logic                     rlast;
  logic                     rvalid;
  logic                     rready;

  modport master (
    output awaddr, awlen, awburst, awvalid, wdata, wlast, wvalid, bready,
    output araddr, arlen, arburst, arvalid, rready,
    input  awready, wready, bvalid, bresp, arready, rdata, rlast, rvalid
  );

  modport slave (
    input  awaddr, awlen, awburst, awvalid, wdata, wlast, wvalid, bready,
    input  araddr, arlen, arburst, arvalid, rready,
    output awready, wready, bvalid, bresp, arready, rdata, rlast, rvalid
  );
endinterface

// File: rtl/spi_axi4_burst_bridge.sv
// SPI strobe-per-beat to AXI4 manager bridge with independent write/read burst channels.
// Define AXI4_FIXED_BURST_EN for FIXED bursts (address held); default is INCR.
module spi_axi4_burst_bridge #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int LEN_WIDTH     = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] spi_write_address,
  input  logic                     spi_write_address_valid,
  input  logic [DATA_WIDTH-1:0]    spi_write_data,
  input  logic                     spi_write_strobe,
  input  logic [LEN_WIDTH-1:0]     spi_write_burst_length,
  input  logic [ADDRESS_WIDTH-1:0] spi_read_address,
  input  logic                     spi_read_address_valid,
  input  logic                     spi_read_strobe,
  input  logic [LEN_WIDTH-1:0]     spi_read_burst_length,
  output logic [DATA_WIDTH-1:0]    spi_read_data,
  output logic                     last_write_ok,
  output logic [31:0]              error_count,
  output logic                     rlast_mismatch,
  spi_axi4_burst_bridge_if.master  axi
);

`ifdef AXI4_FIXED_BURST_EN
  localparam logic [2:0]               BURST_MODE = 3'b001;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP  = '0;
`else
  localparam logic [2:0]               BURST_MODE = 3'b010;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP  = ADDRESS_WIDTH'(1);
`endif

  typedef enum logic {W_IDLE, W_BUSY} wr_state_e;
  typedef enum logic {R_IDLE, R_BUSY} rd_state_e;

  wr_state_e                w_state_q, w_state_d;
  logic [2:0]               w_mask_q, w_mask_d;
  logic [LEN_WIDTH-1:0]     w_count_q, w_count_d;
  logic [ADDRESS_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [LEN_WIDTH-1:0]     awlen_q, awlen_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q, wvalid_d;
  logic                     wlast_q, wlast_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     bready_q, bready_d;
  logic                     last_write_ok_q, last_write_ok_d;
  logic                     w_err;

  rd_state_e                r_state_q, r_state_d;
  logic [1:0]               r_mask_q, r_mask_d;
  logic [LEN_WIDTH-1:0]     r_count_q, r_count_d;
  logic [ADDRESS_WIDTH-1:0] araddr_q, araddr_d;
  logic [LEN_WIDTH-1:0]     arlen_q, arlen_d;
  logic                     arvalid_q, arvalid_d;
  logic                     rready_q, rready_d;
  logic                     exp_last_q, exp_last_d;
  logic [DATA_WIDTH-1:0]    spi_read_data_q, spi_read_data_d;
  logic                     r_err;

  logic [31:0]              error_count_q, error_count_d;

  // Write channel: mask bits {B,W,AW} retire independently; idle once all clear.
  always_comb begin
    w_state_d       = w_state_q;
    w_mask_d        = w_mask_q;
    w_count_d       = w_count_q;
    awaddr_d        = awaddr_q;
    awlen_d         = awlen_q;
    awvalid_d       = awvalid_q;
    wvalid_d        = wvalid_q;
    wlast_d         = wlast_q;
    wdata_d         = wdata_q;
    bready_d        = bready_q;
    last_write_ok_d = last_write_ok_q;
    w_err           = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (spi_write_strobe) begin
          if (spi_write_address_valid) begin
            awaddr_d  = spi_write_address;
            awlen_d   = spi_write_burst_length;
            wlast_d   = (spi_write_burst_length == LEN_WIDTH'(1));
            w_err     = (w_count_q != '0);
            w_count_d = spi_write_burst_length - LEN_WIDTH'(1);
          end else begin
            if (w_count_q != '0) begin
              w_count_d = w_count_q - LEN_WIDTH'(1);
              if (w_count_q == LEN_WIDTH'(1)) wlast_d = 1'b1;
            end else begin
              w_err = 1'b1;
            end
            awaddr_d = awaddr_q + ADDR_STEP;
          end
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          bready_d  = 1'b1;
          wdata_d   = spi_write_data;
          w_mask_d  = 3'b111;
          w_state_d = W_BUSY;
        end
      end
      W_BUSY: begin
        if (w_mask_q[0] && axi.awready) begin
          awvalid_d   = 1'b0;
          w_mask_d[0] = 1'b0;
        end
        if (w_mask_q[1] && axi.wready) begin
          wvalid_d    = 1'b0;
          wlast_d     = 1'b0;
          w_mask_d[1] = 1'b0;
        end
        if (w_mask_q[2] && axi.bvalid) begin
          last_write_ok_d = axi.bresp;
          bready_d        = 1'b0;
          w_mask_d[2]     = 1'b0;
        end
        if (w_mask_d == 3'b000) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel mirrors the write rules; exp_last tracks which beat should carry rlast.
  always_comb begin
    r_state_d       = r_state_q;
    r_mask_d        = r_mask_q;
    r_count_d       = r_count_q;
    araddr_d        = araddr_q;
    arlen_d         = arlen_q;
    arvalid_d       = arvalid_q;
    rready_d        = rready_q;
    exp_last_d      = exp_last_q;
    spi_read_data_d = spi_read_data_q;
    r_err           = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (spi_read_strobe) begin
          if (spi_read_address_valid) begin
            araddr_d   = spi_read_address;
            arlen_d    = spi_read_burst_length;
            exp_last_d = (spi_read_burst_length == LEN_WIDTH'(1));
            r_err      = (r_count_q != '0);
            r_count_d  = spi_read_burst_length - LEN_WIDTH'(1);
          end else begin
            if (r_count_q != '0) begin
              r_count_d = r_count_q - LEN_WIDTH'(1);
              if (r_count_q == LEN_WIDTH'(1)) exp_last_d = 1'b1;
            end else begin
              r_err = 1'b1;
            end
            araddr_d = araddr_q + ADDR_STEP;
          end
          arvalid_d = 1'b1;
          rready_d  = 1'b1;
          r_mask_d  = 2'b11;
          r_state_d = R_BUSY;
        end
      end
      R_BUSY: begin
        if (r_mask_q[0] && axi.arready) begin
          arvalid_d   = 1'b0;
          r_mask_d[0] = 1'b0;
        end
        if (r_mask_q[1] && axi.rvalid) begin
          spi_read_data_d = axi.rdata;
          rready_d        = 1'b0;
          exp_last_d      = 1'b0;
          r_mask_d[1]     = 1'b0;
        end
        if (r_mask_d == 2'b00) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    error_count_d = error_count_q + 32'(w_err) + 32'(r_err);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state_q       <= W_IDLE;
      w_mask_q        <= 3'b000;
      w_count_q       <= '0;
      awaddr_q        <= '0;
      awlen_q         <= LEN_WIDTH'(1);
      awvalid_q       <= 1'b0;
      wvalid_q        <= 1'b0;
      wlast_q         <= 1'b0;
      wdata_q         <= '0;
      bready_q        <= 1'b1;
      last_write_ok_q <= 1'b0;
      r_state_q       <= R_IDLE;
      r_mask_q        <= 2'b00;
      r_count_q       <= '0;
      araddr_q        <= '0;
      arlen_q         <= LEN_WIDTH'(1);
      arvalid_q       <= 1'b0;
      rready_q        <= 1'b0;
      exp_last_q      <= 1'b0;
      spi_read_data_q <= '0;
      error_count_q   <= '0;
    end else begin
      w_state_q       <= w_state_d;
      w_mask_q        <= w_mask_d;
      w_count_q       <= w_count_d;
      awaddr_q        <= awaddr_d;
      awlen_q         <= awlen_d;
      awvalid_q       <= awvalid_d;
      wvalid_q        <= wvalid_d;
      wlast_q         <= wlast_d;
      wdata_q         <= wdata_d;
      bready_q        <= bready_d;
      last_write_ok_q <= last_write_ok_d;
      r_state_q       <= r_state_d;
      r_mask_q        <= r_mask_d;
      r_count_q       <= r_count_d;
      araddr_q        <= araddr_d;
      arlen_q         <= arlen_d;
      arvalid_q       <= arvalid_d;
      rready_q        <= rready_d;
      exp_last_q      <= exp_last_d;
      spi_read_data_q <= spi_read_data_d;
      error_count_q   <= error_count_d;
    end
  end

  assign axi.awaddr     = awaddr_q;
  assign axi.awlen      = awlen_q;
  assign axi.awburst    = BURST_MODE;
  assign axi.awvalid    = awvalid_q;
  assign axi.wdata      = wdata_q;
  assign axi.wlast      = wlast_q;
  assign axi.wvalid     = wvalid_q;
  assign axi.bready     = bready_q;
  assign axi.araddr     = araddr_q;
  assign axi.arlen      = arlen_q;
  assign axi.arburst    = BURST_MODE;
  assign axi.arvalid    = arvalid_q;
  assign axi.rready     = rready_q;
  assign spi_read_data  = spi_read_data_q;
  assign last_write_ok  = last_write_ok_q;
  assign error_count    = error_count_q;
  assign rlast_mismatch = axi.rlast ^ exp_last_q;

endmodule

// File: tb/tb_spi_axi4_burst_bridge.sv
// Directed bench for spi_axi4_burst_bridge with a small AXI4 memory peripheral model.
module tb_spi_axi4_burst_bridge;

`ifdef AXI4_FIXED_BURST_EN
  localparam bit         FIXED_MODE = 1'b1;
  localparam logic [2:0] EXP_BURST  = 3'b001;
`else
  localparam bit         FIXED_MODE = 1'b0;
  localparam logic [2:0] EXP_BURST  = 3'b010;
`endif

  logic        clock;
  logic        reset;
  logic [3:0]  spi_write_address;
  logic        spi_write_address_valid;
  logic [31:0] spi_write_data;
  logic        spi_write_strobe;
  logic [4:0]  spi_write_burst_length;
  logic [3:0]  spi_read_address;
  logic        spi_read_address_valid;
  logic        spi_read_strobe;
  logic [4:0]  spi_read_burst_length;
  logic [31:0] spi_read_data;
  logic        last_write_ok;
  logic [31:0] error_count;
  logic        rlast_mismatch;

  logic        awready_drive;
  logic        bresp_drive;
  logic        rlast_drive;
  logic [3:0]  aw_addr_r;
  logic [31:0] mem [16];

  int checks;
  int failures;

  spi_axi4_burst_bridge_if #(.ADDRESS_WIDTH(4), .DATA_WIDTH(32), .LEN_WIDTH(5)) axi ();

  spi_axi4_burst_bridge #(.ADDRESS_WIDTH(4), .DATA_WIDTH(32), .LEN_WIDTH(5)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .spi_write_address       (spi_write_address),
    .spi_write_address_valid (spi_write_address_valid),
    .spi_write_data          (spi_write_data),
    .spi_write_strobe        (spi_write_strobe),
    .spi_write_burst_length  (spi_write_burst_length),
    .spi_read_address        (spi_read_address),
    .spi_read_address_valid  (spi_read_address_valid),
    .spi_read_strobe         (spi_read_strobe),
    .spi_read_burst_length   (spi_read_burst_length),
    .spi_read_data           (spi_read_data),
    .last_write_ok           (last_write_ok),
    .error_count             (error_count),
    .rlast_mismatch          (rlast_mismatch),
    .axi                     (axi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign axi.awready = awready_drive;
  assign axi.wready  = 1'b1;
  assign axi.arready = 1'b1;

  // Peripheral: B follows an accepted W by one cycle, R follows an accepted AR by one cycle.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      aw_addr_r  <= 4'h0;
      axi.bvalid <= 1'b0;
      axi.bresp  <= 1'b0;
      axi.rvalid <= 1'b0;
      axi.rdata  <= 32'h0;
      axi.rlast  <= 1'b0;
    end else begin
      if (axi.awvalid && axi.awready) aw_addr_r <= axi.awaddr;
      if (axi.wvalid && axi.wready) begin
        axi.bvalid <= 1'b1;
        axi.bresp  <= bresp_drive;
      end else if (axi.bvalid && axi.bready) begin
        axi.bvalid <= 1'b0;
      end
      if (axi.arvalid && axi.arready) begin
        axi.rvalid <= 1'b1;
        axi.rdata  <= mem[axi.araddr];
        axi.rlast  <= rlast_drive;
      end else if (axi.rvalid && axi.rready) begin
        axi.rvalid <= 1'b0;
        axi.rlast  <= 1'b0;
      end
    end
  end

  always @(posedge clock) begin
    if (axi.wvalid && axi.wready)
      mem[(axi.awvalid && axi.awready) ? axi.awaddr : aw_addr_r] <= axi.wdata;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one strobe cycle from a negedge and returns at the negedge after it was sampled.
  task automatic apply_stimulus(input logic wr_en, input logic wr_av, input logic [3:0] wr_addr,
                                input logic [4:0] wr_len, input logic [31:0] wr_data,
                                input logic rd_en, input logic rd_av, input logic [3:0] rd_addr,
                                input logic [4:0] rd_len);
    spi_write_strobe        = wr_en;
    spi_write_address_valid = wr_av;
    spi_write_address       = wr_addr;
    spi_write_burst_length  = wr_len;
    spi_write_data          = wr_data;
    spi_read_strobe         = rd_en;
    spi_read_address_valid  = rd_av;
    spi_read_address        = rd_addr;
    spi_read_burst_length   = rd_len;
    @(negedge clock);
    spi_write_strobe = 1'b0;
    spi_read_strobe  = 1'b0;
  endtask

  task automatic write_beat(input string tag, input logic av, input logic [3:0] addr,
                            input logic [4:0] len, input logic [31:0] data,
                            input logic [3:0] exp_addr, input logic [4:0] exp_len, input logic exp_last);
    apply_stimulus(1'b1, av, addr, len, data, 1'b0, 1'b0, 4'h0, 5'd1);
    check_output({tag, ".awvalid"}, axi.awvalid, 1);
    check_output({tag, ".wvalid"}, axi.wvalid, 1);
    check_output({tag, ".awaddr"}, axi.awaddr, exp_addr);
    check_output({tag, ".awlen"}, axi.awlen, exp_len);
    check_output({tag, ".wlast"}, axi.wlast, exp_last);
    check_output({tag, ".wdata"}, axi.wdata, data);
    repeat (2) @(negedge clock);
    check_output({tag, ".done_awvalid"}, axi.awvalid, 0);
    check_output({tag, ".done_wvalid"}, axi.wvalid, 0);
    check_output({tag, ".done_bready"}, axi.bready, 0);
  endtask

  task automatic read_beat(input string tag, input logic av, input logic [3:0] addr,
                           input logic [4:0] len, input logic [3:0] exp_addr,
                           input logic exp_last, input logic [31:0] exp_data);
    rlast_drive = exp_last;
    apply_stimulus(1'b0, 1'b0, 4'h0, 5'd1, 32'h0, 1'b1, av, addr, len);
    check_output({tag, ".arvalid"}, axi.arvalid, 1);
    check_output({tag, ".rready"}, axi.rready, 1);
    check_output({tag, ".araddr"}, axi.araddr, exp_addr);
    check_output({tag, ".arlen"}, axi.arlen, 2);
    @(negedge clock);
    check_output({tag, ".arvalid_drop"}, axi.arvalid, 0);
    check_output({tag, ".rlast_mismatch"}, rlast_mismatch, 0);
    @(negedge clock);
    check_output({tag, ".rready_drop"}, axi.rready, 0);
    check_output({tag, ".spi_read_data"}, spi_read_data, exp_data);
    rlast_drive = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    awready_drive = 1'b1;
    bresp_drive = 1'b0;
    rlast_drive = 1'b0;
    spi_write_strobe = 1'b0;
    spi_write_address_valid = 1'b0;
    spi_write_address = 4'h0;
    spi_write_burst_length = 5'd1;
    spi_write_data = 32'h0;
    spi_read_strobe = 1'b0;
    spi_read_address_valid = 1'b0;
    spi_read_address = 4'h0;
    spi_read_burst_length = 5'd1;
    repeat (3) @(negedge clock);

    check_output("rst.awvalid", axi.awvalid, 0);
    check_output("rst.wvalid", axi.wvalid, 0);
    check_output("rst.arvalid", axi.arvalid, 0);
    check_output("rst.wlast", axi.wlast, 0);
    check_output("rst.rready", axi.rready, 0);
    check_output("rst.bready", axi.bready, 1);
    check_output("rst.awlen", axi.awlen, 1);
    check_output("rst.arlen", axi.arlen, 1);
    check_output("rst.awaddr", axi.awaddr, 0);
    check_output("rst.error_count", error_count, 0);
    check_output("rst.last_write_ok", last_write_ok, 0);
    check_output("rst.spi_read_data", spi_read_data, 0);
    check_output("rst.rlast_mismatch", rlast_mismatch, 0);
    check_output("rst.awburst", axi.awburst, EXP_BURST);
    check_output("rst.arburst", axi.arburst, EXP_BURST);
    reset = 1'b1;
    @(negedge clock);

    bresp_drive = 1'b1;
    write_beat("single", 1'b1, 4'h1, 5'd1, 32'habcdef01, 4'h1, 5'd1, 1'b1);
    check_output("single.last_write_ok", last_write_ok, 1);
    check_output("single.error_count", error_count, 0);

    bresp_drive = 1'b0;
    write_beat("burst2.b1", 1'b1, 4'hc, 5'd2, 32'h55550000, 4'hc, 5'd2, 1'b0);
    check_output("burst2.last_write_ok", last_write_ok, 0);
    write_beat("burst2.b2", 1'b0, 4'h0, 5'd0, 32'h44bb44bb, FIXED_MODE ? 4'hc : 4'hd, 5'd2, 1'b1);

    read_beat("read.b1", 1'b1, 4'hc, 5'd2, 4'hc, 1'b0, FIXED_MODE ? 32'h44bb44bb : 32'h55550000);
    read_beat("read.b2", 1'b0, 4'h0, 5'd0, FIXED_MODE ? 4'hc : 4'hd, 1'b1, 32'h44bb44bb);

    for (int i = 0; i < 19; i++) begin
      write_beat($sformatf("burst19.b%0d", i + 1), i == 0, 4'h0, 5'd19, 32'h10000000 + 32'(i),
                 FIXED_MODE ? 4'h0 : 4'(i), 5'd19, i == 18);
    end
    check_output("burst19.error_count", error_count, 0);

    write_beat("err_cont", 1'b0, 4'h0, 5'd0, 32'h0000aaaa, FIXED_MODE ? 4'h0 : 4'h3, 5'd19, 1'b0);
    check_output("err_cont.error_count", error_count, 1);
    write_beat("len3.b1", 1'b1, 4'h5, 5'd3, 32'h0000bbbb, 4'h5, 5'd3, 1'b0);
    check_output("len3.error_count", error_count, 1);
    write_beat("err_restart", 1'b1, 4'h8, 5'd1, 32'h0000cccc, 4'h8, 5'd1, 1'b1);
    check_output("err_restart.error_count", error_count, 2);

    bresp_drive = 1'b1;
    rlast_drive = 1'b1;
    apply_stimulus(1'b1, 1'b0, 4'h0, 5'd0, 32'h0d0d0d0d, 1'b1, 1'b0, 4'h0, 5'd0);
    check_output("dual.awaddr", axi.awaddr, FIXED_MODE ? 4'h8 : 4'h9);
    check_output("dual.araddr", axi.araddr, FIXED_MODE ? 4'hc : 4'he);
    check_output("dual.awvalid", axi.awvalid, 1);
    check_output("dual.arvalid", axi.arvalid, 1);
    check_output("dual.error_count", error_count, 4);
    @(negedge clock);
    check_output("dual.rlast_mismatch", rlast_mismatch, 1);
    @(negedge clock);
    check_output("dual.spi_read_data", spi_read_data, FIXED_MODE ? 32'h44bb44bb : 32'h1000000e);
    check_output("dual.last_write_ok", last_write_ok, 1);
    rlast_drive = 1'b0;

    awready_drive = 1'b0;
    apply_stimulus(1'b1, 1'b1, 4'h7, 5'd1, 32'h77777777, 1'b0, 1'b0, 4'h0, 5'd1);
    check_output("stall.awvalid", axi.awvalid, 1);
    @(negedge clock);
    check_output("stall.awvalid_held", axi.awvalid, 1);
    #2 reset = 1'b0;
    #1;
    check_output("async_rst.awvalid", axi.awvalid, 0);
    check_output("async_rst.wvalid", axi.wvalid, 0);
    check_output("async_rst.awaddr", axi.awaddr, 0);
    check_output("async_rst.awlen", axi.awlen, 1);
    check_output("async_rst.wlast", axi.wlast, 0);
    check_output("async_rst.wdata", axi.wdata, 0);
    check_output("async_rst.bready", axi.bready, 1);
    check_output("async_rst.araddr", axi.araddr, 0);
    check_output("async_rst.rready", axi.rready, 0);
    check_output("async_rst.error_count", error_count, 0);
    check_output("async_rst.last_write_ok", last_write_ok, 0);
    check_output("async_rst.spi_read_data", spi_read_data, 0);
    awready_drive = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    write_beat("post_rst", 1'b1, 4'h2, 5'd1, 32'h12345678, 4'h2, 5'd1, 1'b1);
    check_output("post_rst.error_count", error_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_axi4_burst_bridge.md
# spi_axi4_burst_bridge

Bridges a strobe-per-beat SPI-side register interface onto an AXI4 controller (manager) port, with independent write and read burst channels. Each SPI strobe issues exactly one AXI beat; the first beat of a burst carries the start address and length, and subsequent beats auto-increment the address. The block sits between the SPI peripheral decoder and an AXI4 memory-mapped peripheral such as a pollable register memory.

## Interface
- ADDRESS_WIDTH, 4, AXI/SPI address width
- DATA_WIDTH, 32, data width
- LEN_WIDTH, 5, burst-length width (beats, 1-based)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- spi_write_address / spi_read_address  in  ADDRESS_WIDTH  burst start address
- spi_write_address_valid / spi_read_address_valid  in  1  marks the first beat of a burst
- spi_write_data  in  DATA_WIDTH  beat write data
- spi_write_strobe / spi_read_strobe  in  1  one-cycle beat request
- spi_write_burst_length / spi_read_burst_length  in  LEN_WIDTH  beats in burst
- spi_read_data  out  DATA_WIDTH  last captured read data
- awaddr, araddr  out  ADDRESS_WIDTH; awlen, arlen  out  LEN_WIDTH; awburst, arburst  out  3 (FIXED=001, INCR=010, WRAP=100)
- awvalid, wvalid, wlast, bready, arvalid, rready  out  1; wdata  out  DATA_WIDTH
- awready, wready, bvalid, bresp, arready, rvalid, rlast  in  1; rdata  in  DATA_WIDTH
- last_write_ok  out  1  bresp of most recent write
- error_count  out  32  protocol-misuse counter
- rlast_mismatch  out  1  rlast XOR internal expected-last flag

## Operation
- awburst/arburst constant (see Configuration); WRAP never driven.
- Write FSM: 3-bit pending mask {B,W,AW}; idle when 0. Strobes while busy are ignored.
- Idle + spi_write_strobe:
  - address_valid=1: awaddr<=spi addr, awlen<=length, wlast<=1 if length==1, error_count+1 if beat counter!=0, counter<=length-1.
  - address_valid=0: if counter>0 {counter-1; wlast<=1 if counter==1} else error_count+1; awaddr+1 (mod 2^ADDRESS_WIDTH) when INCR.
  - Always: awvalid<=1, wvalid<=1, bready<=1, wdata<=spi_write_data, mask<=111.
- Busy: AW pending & awready -> awvalid<=0, clear AW. W pending & wready -> wvalid<=0, wlast<=0, clear W. B pending & bvalid -> last_write_ok<=bresp, bready<=0, clear B. Bits clear independently, same cycle allowed.
- Read FSM: 2-bit mask {R,AR}; same first/continuation rules on araddr/arlen/counter; expected-last flag set as wlast is. Issue: arvalid<=1, rready<=1, mask<=11.
- Busy: AR pending & arready -> arvalid<=0. R pending & rvalid -> spi_read_data<=rdata, rready<=0, expected-last<=0.
- Channels independent; simultaneous write and read errors in one cycle add 2.
- error_count wraps modulo 2^32.

## Timing
- Reset values: awaddr/araddr/wdata/spi_read_data 0, awlen/arlen 1, all valids 0, wlast 0, rready 0, bready 1, last_write_ok 0, error_count 0, counters 0, FSMs idle.
- Reset mid-burst aborts immediately; peripheral side must also reset.
- Strobe to awvalid/wvalid/arvalid high: 1 cycle (registered).
- Valid drops the cycle after ready is sampled high while pending; next beat accepted the cycle after the mask reaches 0.
- bready stays low between write completion and the next write strobe.

## Configuration
- AXI4_FIXED_BURST_EN: defined -> awburst=arburst=FIXED, address held across beats. Undefined -> INCR, address +1 per continuation beat.

## Test plan
- Single write addr 0x1, len 1, data 0xabcdef01 -> awaddr=1, awlen=1, wlast=1 on the beat; bresp=1 gives last_write_ok=1; error_count 0.
- Write burst addr 0xc, len 2, data 0x55550000, 0x44bb44bb -> awaddr 0xc then 0xd; wlast only on beat 2.
- Burst len 19 from 0x0 -> awaddr wraps 0xf->0x0; wlast only on beat 19; error_count 0.
- Read addr 0xc, len 2 after above writes -> spi_read_data 0x55550000 then 0x44bb44bb; rlast_mismatch stays 0.
- Continuation strobe with counter 0, or new burst with counter!=0 -> error_count +1 each.
- Reset asserted while awvalid high -> all outputs return to reset values asynchronously.
